// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and helpers for the wide-add sequencer.
// Slice width, FSM state encoding and index-width helper.
package add_seq_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: runs WORDS x 16-bit adds through one external adder.
// Optional subtract mode (op_sub port) when ADD_SEQ_SUB_EN is defined.
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [16*WORDS-1:0]    op_a,
   input  logic [16*WORDS-1:0]    op_b,
   input  logic                   op_cin,
`ifdef ADD_SEQ_SUB_EN
   input  logic                   op_sub,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [16*WORDS-1:0]    result,
   output logic                   result_cout,
   output logic                   result_ovf,
   output logic                   busy,
   output logic [15:0]            add_ina,
   output logic [15:0]            add_inb,
   output logic                   add_cin,
   input  logic [15:0]            add_sum,
   input  logic                   add_cout
);

   localparam int W  = SLICE_W * WORDS;
   localparam int IW = idx_width(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    res_q, res_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;
   logic [IW-1:0]   idx_q, idx_d;

   logic                start_sub;
   logic [SLICE_W-1:0]  a_sl;
   logic [SLICE_W-1:0]  b_sl;

`ifdef ADD_SEQ_SUB_EN
   assign start_sub = op_sub;
`else
   assign start_sub = 1'b0;
`endif

   // B is stored pre-inverted for subtract, so overflow and slices need no mode bit
   assign a_sl = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
   assign b_sl = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and slice capture logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = start_sub ? ~op_b : op_b;
               carry_d = start_sub ? 1'b1 : op_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[int'(idx_q)*SLICE_W +: SLICE_W] = add_sum;
            carry_d = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               idx_d   = '0;
               cout_d  = add_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                         (add_sum[SLICE_W-1] != a_q[W-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and adder drive outputs decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      add_ina   = '0;
      add_inb   = '0;
      add_cin   = 1'b0;
      unique case (state_q)
         IDLE: in_ready = 1'b1;
         RUN: begin
            busy    = 1'b1;
            add_ina = a_sl;
            add_inb = b_sl;
            add_cin = carry_q;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign result      = res_q;
   assign result_cout = cout_q;
   assign result_ovf  = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: scoreboard bench for add_seq_ctrl, WORDS=4.
// Behavioural 16-bit adder stands in for the external rca.
module tb_add_seq_ctrl;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          op_cin;
   logic          op_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          result_cout;
   logic          result_ovf;
   logic          busy;
   logic [15:0]   add_ina;
   logic [15:0]   add_inb;
   logic          add_cin;
   logic [15:0]   add_sum;
   logic          add_cout;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_ina} + {1'b0, add_inb}
                                + {16'b0, add_cin};

   add_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_cin      (op_cin),
`ifdef ADD_SEQ_SUB_EN
      .op_sub      (op_sub),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_cout (result_cout),
      .result_ovf  (result_ovf),
      .busy        (busy),
      .add_ina     (add_ina),
      .add_inb     (add_inb),
      .add_cin     (add_cin),
      .add_sum     (add_sum),
      .add_cout    (add_cout)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      int           t_acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_acc = 0;
   bit   bp_en = 1'b0;
   bit   prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   // Reference: full-width arithmetic on the whole operands
   function automatic exp_t model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         e;
      logic [W:0]   s;
      logic [W-1:0] bb;
      logic         c;
      bb = sub ? ~b : b;
      c  = sub ? 1'b1 : cin;
      s  = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
      e.res   = s[W-1:0];
      e.cout  = s[W];
      e.ovf   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
      e.t_acc = 0;
      return e;
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      int   t;
      exp_t e;
      t = 0;
      @(posedge clk); #1;
      while (!in_ready) begin
         if (t > 100) begin
            timeout("send_wait_ready");
            return;
         end
         if (bp_en) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         t++;
      end
      op_a     = a;
      op_b     = b;
      op_cin   = cin;
      op_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = model(a, b, cin, sub);
      e.t_acc = cyc;
      last_acc = cyc;
      q.push_back(e);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() > 0 && t < 200) begin
         out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         t++;
      end
      if (q.size() > 0) begin
         timeout("drain");
         q.delete();
      end
      out_ready = 1'b1;
   endtask

   // Monitor: compare every presented result against the queue head
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got result %h, none expected",
                     result);
         end else begin
            if (!prev_v)
               chk("latency", W'(cyc - q[0].t_acc), W'(WORDS));
            chk("result", result, q[0].res);
            chk("cout", W'(result_cout), W'(q[0].cout));
            chk("ovf", W'(result_ovf), W'(q[0].ovf));
            chk("done_in_ready", W'(in_ready), W'(0));
            if (out_ready) void'(q.pop_front());
         end
      end
      prev_v = out_valid;
   end

   initial begin
      int t0;
      int t;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_cin    = 1'b0;
      op_sub    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_result", result, W'(0));
      chk("rst_cout", W'(result_cout), W'(0));
      chk("rst_ovf", W'(result_ovf), W'(0));
      chk("rst_add_ina", W'(add_ina), W'(0));
      chk("rst_add_cin", W'(add_cin), W'(0));

      send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
      drain();
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      drain();
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      drain();
      send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
      drain();
      send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
      drain();
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      drain();

      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      t0 = last_acc;
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
      chk("throughput", W'(last_acc - t0), W'(WORDS + 2));
      drain();

      out_ready = 1'b0;
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!out_valid) timeout("stall_wait_valid");
      @(posedge clk); #1;
      op_a     = {$urandom, $urandom};
      op_b     = {$urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("stall_busy", W'(busy), W'(1));
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();
      repeat (10) @(posedge clk);
      #1;

      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
      chk("run_busy", W'(busy), W'(1));
      chk("run_in_ready", W'(in_ready), W'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      chk("mid_rst_in_ready", W'(in_ready), W'(1));
      chk("mid_rst_out_valid", W'(out_valid), W'(0));
      chk("mid_rst_busy", W'(busy), W'(0));
      repeat (8) @(posedge clk);
      #1;
      send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
      drain();

`ifdef ADD_SEQ_SUB_EN
      send(64'd5, 64'd7, 1'b0, 1'b1);
      drain();
      send(64'd7, 64'd5, 1'b1, 1'b1);
      drain();
`endif

      bp_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) a = '1;
         if ($urandom_range(0, 7) == 0) b = {1'b0, {(W-1){1'b1}}};
`ifdef ADD_SEQ_SUB_EN
         send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
         send(a, b, 1'($urandom_range(0, 1)), 1'b0);
`endif
      end
      drain();
      bp_en = 1'b0;
      repeat (5) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
